// File: rtl/comp_nbit_serial.sv
// comp_nbit_serial: bit-serial (g_input >= e_input) comparator, W bits per cycle, LSB chunk first.
// Latency: N/W+1 edges from the accepted start to the done pulse; one result per N/W+1 cycles.
// Backpressure: none; start is ignored while busy and is accepted only in IDLE or DONE.
// Build option: define COMP_SERIAL_SIGNED_EN to compare two's complement operands.
module comp_nbit_serial #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] g_input,
  input  logic [N-1:0] e_input,
  output logic         busy,
  output logic         done,
  output logic         o
);

  localparam int            CHUNKS = N / W;
  localparam int            CW     = $clog2(CHUNKS) + 1;
  localparam logic [CW-1:0] LAST   = CW'(CHUNKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef COMP_SERIAL_SIGNED_EN
  // Inverting the sign bit maps two's complement onto offset binary, so the
  // plain unsigned chunk compare orders the final (sign-carrying) chunk correctly.
  localparam logic [N-1:0] LOAD_FLIP = N'(1) << (N - 1);
`else
  localparam logic [N-1:0] LOAD_FLIP = '0;
`endif

  generate
    if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("comp_nbit_serial: parameters need 1 <= W <= N and N divisible by W");
    end
  endgenerate

  logic [1:0]    state;
  logic [N-1:0]  g_sh;
  logic [N-1:0]  e_sh;
  logic          ge;
  logic [CW-1:0] cnt;
  logic [W-1:0]  gc;
  logic [W-1:0]  ec;
  logic          ge_nxt;

  assign gc   = g_sh[W-1:0];
  assign ec   = e_sh[W-1:0];
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Chunk verdict: chunks arrive in rising significance, so any strict
  // inequality overrides whatever the lower chunks decided; equality keeps it.
  always_comb begin
    ge_nxt = ge;
    if (gc > ec) begin
      ge_nxt = 1'b1;
    end else if (gc < ec) begin
      ge_nxt = 1'b0;
    end
  end

  // Control FSM plus operand shifters; o is written only when entering DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      g_sh  <= '0;
      e_sh  <= '0;
      ge    <= 1'b1;
      cnt   <= '0;
      o     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          ge   <= ge_nxt;
          g_sh <= g_sh >> W;
          e_sh <= e_sh >> W;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= S_DONE;
            o     <= ge_nxt;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts one cycle.
          if (start) begin
            g_sh  <= g_input ^ LOAD_FLIP;
            e_sh  <= e_input ^ LOAD_FLIP;
            ge    <= 1'b1;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_nbit_serial.sv
// Scoreboard bench: two instances (N=8 with W=1 and W=4) driven one at a time;
// expected results and done cycles are queued at issue, a monitor checks them.
module tb_comp_nbit_serial;

  localparam int CH0 = 8;  // chunks per compare, W=1
  localparam int CH1 = 2;  // chunks per compare, W=4

  typedef struct {
    int   dut;
    logic o;
    int   cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      start_v = '0;
  logic [1:0][7:0] g_v = '0;
  logic [1:0][7:0] e_v = '0;
  logic [1:0]      busy_v;
  logic [1:0]      done_v;
  logic [1:0]      o_v;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [1:0] last_o = '0;
  logic [1:0] prev_done = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comp_nbit_serial #(.N(8), .W(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .g_input(g_v[0]), .e_input(e_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .o(o_v[0])
  );

  comp_nbit_serial #(.N(8), .W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .g_input(g_v[1]), .e_input(e_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .o(o_v[1])
  );

  // Reference: the comparison as plain integer arithmetic.
  function automatic logic model_ge(input logic [7:0] g, input logic [7:0] e);
`ifdef COMP_SERIAL_SIGNED_EN
    return $signed(g) >= $signed(e);
`else
    return g >= e;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge when dut d is IDLE or DONE, so the next edge accepts.
  // While it runs, start and operands are scrambled; they must be ignored.
  task automatic issue(input int d, input logic [7:0] g, input logic [7:0] e);
    int a;
    int ch;
    exp_t x;
    ch = (d == 0) ? CH0 : CH1;
    g_v[d] = g;
    e_v[d] = e;
    start_v[d] = 1'b1;
    a = cyc + 1;
    x.dut = d;
    x.o = model_ge(g, e);
    x.cyc = a + ch;
    sb.push_back(x);
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy_v[d]}, 32'd1);
    while (cyc < a + ch) begin
      start_v[d] = 1'($urandom);
      g_v[d] = 8'($urandom);
      e_v[d] = 8'($urandom);
      @(negedge clk);
    end
    start_v[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int k);
    for (int i = 0; i < k; i++) begin
      start_v[d] = 1'b0;
      g_v[d] = 8'($urandom);
      e_v[d] = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic rand_ops(input int d, input int n);
    logic [7:0] g;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom);
      e = ($urandom_range(0, 7) == 0) ? g : 8'($urandom);
      idle(d, int'($urandom_range(0, 2)));
      issue(d, g, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] dg0 [8];
    logic [7:0] de0 [8];
    logic [7:0] dg1 [5];
    logic [7:0] de1 [5];
    dg0 = '{8'hA9, 8'h74, 8'hAA, 8'h80, 8'h00, 8'hFF, 8'h00, 8'h7F};
    de0 = '{8'h7B, 8'hFD, 8'hAA, 8'h7F, 8'h00, 8'h00, 8'hFF, 8'h80};
    dg1 = '{8'h3F, 8'h74, 8'h80, 8'hAA, 8'h0F};
    de1 = '{8'h40, 8'hFD, 8'h7F, 8'hAA, 8'hF0};

    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", {31'd0, busy_v[d]}, 32'd0);
      chk("reset_done", {31'd0, done_v[d]}, 32'd0);
      chk("reset_o", {31'd0, o_v[d]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          if (done_v[d]) begin
            chk("done_with_busy", {31'd0, busy_v[d]}, 32'd0);
            chk("done_single_cycle", {31'd0, prev_done[d]}, 32'd0);
            if (sb.size() == 0 || sb[0].dut != d) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_done: dut%0d pulsed done at cycle %0d, no result pending", d, cyc);
            end else begin
              exp_t x;
              x = sb.pop_front();
              chk("result_o", {31'd0, o_v[d]}, {31'd0, x.o});
              chk("done_cycle", cyc, x.cyc);
              last_o[d] = x.o;
            end
          end else begin
            chk("o_hold", {31'd0, o_v[d]}, {31'd0, last_o[d]});
          end
          prev_done[d] = done_v[d];
        end
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL missing_done: dut%0d expected done at cycle %0d, none by cycle %0d",
                   sb[0].dut, sb[0].cyc, cyc);
          void'(sb.pop_front());
        end
      end
    join_none

    // Directed W=1 cases with idle gaps between them.
    for (int i = 0; i < 8; i++) begin
      issue(0, dg0[i], de0[i]);
      idle(0, 1);
    end

    // Reset in the middle of a comparison: outputs clear at once, no done follows.
    issue(0, 8'hA9, 8'h7B);
    idle(0, 2);
    start_v[0] = 1'b1;
    g_v[0] = 8'hA9;
    e_v[0] = 8'h7B;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("midrun_reset_done", {31'd0, done_v[0]}, 32'd0);
    chk("midrun_reset_o", {31'd0, o_v[0]}, 32'd0);
    chk("midrun_reset_o_w4", {31'd0, o_v[1]}, 32'd0);
    sb.delete();
    last_o = '0;
    repeat (CH0 + 2) @(negedge clk);
    rst = 1'b1;
    issue(0, 8'hA9, 8'h7B);
    idle(0, 1);

    // Directed W=4 cases issued back to back (start held through DONE).
    for (int i = 0; i < 5; i++) begin
      issue(1, dg1[i], de1[i]);
    end
    idle(1, 2);

    rand_ops(0, 150);
    idle(0, 2);
    rand_ops(1, 200);
    idle(1, CH0 + 3);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/comp_nbit_serial.md
# comp_nbit_serial

Sequential bit-serial unsigned/signed comparator that computes `o = (g_input >= e_input)` over N/W clock cycles, consuming W bits per cycle starting at the LSB. It is the multi-cycle counterpart of the single-cycle comparator. Its per-cycle logic is one W-bit compare plus one state bit, so the garbled-circuit netlist stays small regardless of N. It sits behind the same g/e operand interface and adds a start/done handshake for use inside sequential datapaths.

## Interface
- `N`, default 8: operand width in bits; must be ≥ 1.
- `W`, default 1: bits compared per cycle; 1 ≤ W ≤ N, and N % W == 0 (elaboration error otherwise).
- `clk` input, 1 bit: clock, rising-edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a comparison; operands are captured on the accepting edge.
- `g_input` input, N bits: garbler operand.
- `e_input` input, N bits: evaluator operand.
- `busy` output, 1 bit: high while a comparison is in progress (state RUN).
- `done` output, 1 bit: one-cycle pulse when `o` becomes valid.
- `o` output, 1 bit: comparison result; 1 iff g ≥ e. Held until the next `done`.

## Operation
- Internal registers:
  - `g_sh`, `e_sh`: N-bit shift registers.
  - `ge`: 1-bit running result.
  - `cnt`: chunk counter, width clog2(N/W)+1.
  - FSM state: IDLE, RUN, DONE.
- IDLE: if `start`=1, load `g_sh`←`g_input`, `e_sh`←`e_input`, set `ge`←1 (equal compares as ≥) and `cnt`←0, then go to RUN. Otherwise stay in IDLE.
- RUN, each cycle:
  - Take chunk `gc = g_sh[W-1:0]` and `ec = e_sh[W-1:0]`.
  - If gc > ec (unsigned), `ge`←1. If gc < ec, `ge`←0. If equal, `ge` is unchanged.
  - Shift both registers right by W and increment `cnt`.
  - When `cnt` reaches N/W−1 this cycle, go to DONE.
- DONE: `o`←`ge` and `done`=1 for exactly this cycle.
  - If `start`=1 in DONE, capture new operands (same as the IDLE load) and go directly to RUN.
  - Otherwise go to IDLE.
- `start` while in RUN is ignored; operands are not re-sampled.
- Operand changes after capture have no effect on the comparison in progress.
- Only the FSM, `cnt`, `ge` and the shift registers are stateful; there is no combinational path from inputs to `o`.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `o`=0, `ge`=1, `cnt`=0, shift registers cleared.
  - Applies immediately, including mid-RUN; the aborted comparison produces no `done`.
- Deassertion of `rst` is synchronized externally; the first `start` is accepted on the first rising edge with `rst`=1.
- Latency: `start` is sampled at edge T0.
  - `busy`=1 from after T0 through the edge at T0+N/W.
  - `done`=1 and `o` valid in the cycle following edge T0+N/W.
  - Result: N/W+1 edges from start to `done`.
- Throughput: with `start` held high, one result every N/W+1 cycles.
- `done` is registered, never high for two consecutive cycles, and never high together with `busy`.
- `o` updates only on the edge entering DONE.

## Configuration
- Macro `COMP_SERIAL_SIGNED_EN`.
  - Defined: operands are two's complement. On the load edge, the MSB of both operands is inverted before storing into `g_sh`/`e_sh`, so the last chunk compares with sign-correct ordering. Latency is unchanged.
  - Undefined: unsigned comparison, as described in Operation.

## Test plan
- N=8, W=1, unsigned: g=0xA9, e=0x7B, pulse `start` → `busy` for 8 cycles, then `done`=1 with `o`=1.
- N=8, W=1, unsigned: g=0x74, e=0xFD → `o`=0. Then g=0xAA, e=0xAA → `o`=1 (equality).
- N=8, W=4: g=0x3F, e=0x40 → `done` 3 edges after `start`, `o`=0. With `start` held high, the next result follows 3 cycles later.
- `COMP_SERIAL_SIGNED_EN` defined, N=8, W=1:
  - g=0x74, e=0xFD → `o`=1 (116 ≥ −3).
  - g=0x80, e=0x7F → `o`=0.
- Reset mid-operation: start g=0xA9, e=0x7B, drive `rst`=0 after 3 cycles → `busy`, `done` and `o` go to 0 immediately. No `done` follows. A new start then gives the correct result.
- Robustness:
  - Toggle `start` and change operands during RUN → result reflects only the captured operands.
  - `done` stays a single cycle.
